// File: rtl/pd_stage.sv
// Two-wide predict stage: owns the fetch PC and predicts both slots with a
// gshare PHT, a direct-mapped BTB and a return address stack.
// Ports: CLK/reset (async high); EX resolution and repair inputs
// (mispredict, restore_*, update_*, snapshots); pd_* prediction outputs.
module pd_stage #(
  parameter int PHT_ADDRESS = 9,
  parameter int GHR_SIZE    = 9,
  parameter int XLEN        = 32,
  parameter int RAS_ADDRESS = 3
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   actual_taken,
  input  logic                   mispredict,
  input  logic                   restore_ghr,
  input  logic                   restore_ras,
  input  logic                   update_pht,
  input  logic                   update_btb,
  input  logic                   update_ras,
  input  logic                   ex_is_ret,
  input  logic                   ex_is_branch,
  input  logic [XLEN-1:0]        actual_target_address,
  input  logic [XLEN-1:0]        actual_return_address,
  input  logic [XLEN-1:0]        ex_pc,
  input  logic [GHR_SIZE-1:0]    ghr_snap,
  input  logic [PHT_ADDRESS-1:0] rb_pht_index,
  input  logic [RAS_ADDRESS-1:0] rb_sp_snap,
  input  logic [2*XLEN-1:0]      rb_ras_snap,
  output logic [XLEN-1:0]        pd_pc,
  output logic                   pd_pred_taken1,
  output logic                   pd_pred_taken2,
  output logic                   pd_btb_hit1,
  output logic                   pd_btb_hit2,
  output logic [XLEN-1:0]        pd_pred_target1,
  output logic [XLEN-1:0]        pd_pred_target2,
  output logic [PHT_ADDRESS-1:0] pd_pht_index1,
  output logic [PHT_ADDRESS-1:0] pd_pht_index2,
  output logic [RAS_ADDRESS-1:0] pd_sp_snap,
  output logic [2*XLEN-1:0]      pd_ras_snap,
  output logic [GHR_SIZE-1:0]    pd_prev_ghr
);

  localparam int TW = XLEN - PHT_ADDRESS - 2;
  localparam int NE = 2 ** PHT_ADDRESS;
  localparam int NR = 2 ** RAS_ADDRESS;
  localparam logic [RAS_ADDRESS-1:0] ONE = RAS_ADDRESS'(1);
  localparam logic [RAS_ADDRESS-1:0] TWO = RAS_ADDRESS'(2);

  typedef struct packed {
    logic            v;
    logic [TW-1:0]   tag;
    logic [XLEN-1:0] tgt;
    logic            br;
    logic            call;
    logic            ret;
  } btb_t;

  logic [XLEN-1:0]        pc, pc_nxt, pc2;
  logic [GHR_SIZE-1:0]    ghr, ghr_nxt;
  logic [RAS_ADDRESS-1:0] sp;
  logic [1:0]             pht [NE];
  btb_t                   btb [NE];
  logic [XLEN-1:0]        stack [NR];

  logic [PHT_ADDRESS-1:0] set1, set2, wset;
  logic [TW-1:0]          tag1, tag2;
  btb_t                   e1, e2;
  logic [XLEN-1:0]        ras_top, dflt;
  logic                   br1, br2, t1, t2;
  logic [XLEN-1:0]        tg1, tg2;

  // Branch uses the PHT, return uses the RAS top, any other jump is taken.
  function automatic logic [XLEN:0] pred(
    input logic            hit,
    input btb_t            e,
    input logic [1:0]      ctr,
    input logic [XLEN-1:0] ras,
    input logic [XLEN-1:0] fall
  );
    logic [XLEN:0] r;
    r = {1'b0, fall};
    if (hit) begin
      if (e.br)       r = {ctr[1], e.tgt};
      else if (e.ret) r = {1'b1, ras};
      else            r = {1'b1, e.tgt};
    end
    return r;
  endfunction

  always_comb begin
    pc2     = pc + XLEN'(4);
    dflt    = pc + XLEN'(8);
    set1    = pc[PHT_ADDRESS+1:2];
    tag1    = pc[XLEN-1:PHT_ADDRESS+2];
    set2    = pc2[PHT_ADDRESS+1:2];
    tag2    = pc2[XLEN-1:PHT_ADDRESS+2];
    e1      = btb[set1];
    e2      = btb[set2];
    ras_top = stack[sp - ONE];
    pd_btb_hit1   = e1.v && (e1.tag == tag1);
    pd_btb_hit2   = e2.v && (e2.tag == tag2);
    pd_pht_index1 = set1 ^ ghr;
    pd_pht_index2 = set2 ^ ghr;
    {t1, tg1} = pred(pd_btb_hit1, e1, pht[pd_pht_index1], ras_top, dflt);
    {t2, tg2} = pred(pd_btb_hit2, e2, pht[pd_pht_index2], ras_top, dflt);
    br1 = pd_btb_hit1 && e1.br;
    br2 = pd_btb_hit2 && e2.br;
    pd_pred_taken1  = t1;
    pd_pred_taken2  = t2 && !t1;
    pd_pred_target1 = tg1;
    pd_pred_target2 = tg2;
  end

  assign pd_pc       = pc;
  assign pd_prev_ghr = ghr;
  assign pd_sp_snap  = sp;
  assign pd_ras_snap = {stack[sp - TWO], stack[sp - ONE]};
  assign wset        = ex_pc[PHT_ADDRESS+1:2];

  always_comb begin
    pc_nxt = dflt;
    if (mispredict)
      pc_nxt = actual_taken ? actual_target_address : ex_pc + XLEN'(4);
    else if (t1)
      pc_nxt = tg1;
    else if (t2)
      pc_nxt = tg2;
  end

  // Speculative history may take two shifts when slot1 is a not-taken branch.
  always_comb begin
    ghr_nxt = ghr;
    if (restore_ghr) begin
      ghr_nxt = ex_is_branch ? {ghr_snap[GHR_SIZE-2:0], actual_taken}
                             : ghr_snap;
    end else if (!mispredict) begin
      if (br1)
        ghr_nxt = {ghr_nxt[GHR_SIZE-2:0], t1};
      if (br2 && !t1)
        ghr_nxt = {ghr_nxt[GHR_SIZE-2:0], t2};
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pc  <= '0;
      ghr <= '0;
    end else begin
      pc  <= pc_nxt;
      ghr <= ghr_nxt;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NE; i++) pht[i] <= 2'b01;
    end else if (update_pht) begin
      if (actual_taken && pht[rb_pht_index] != 2'b11)
        pht[rb_pht_index] <= pht[rb_pht_index] + 2'b01;
      else if (!actual_taken && pht[rb_pht_index] != 2'b00)
        pht[rb_pht_index] <= pht[rb_pht_index] - 2'b01;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NE; i++) btb[i] <= '0;
    end else if (update_btb) begin
      btb[wset] <= '{v: 1'b1,
                     tag: ex_pc[XLEN-1:PHT_ADDRESS+2],
                     tgt: actual_target_address,
                     br: ex_is_branch,
                     call: update_ras && !ex_is_ret,
                     ret: ex_is_ret};
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sp <= '0;
      for (int i = 0; i < NR; i++) stack[i] <= '0;
    end else if (restore_ras) begin
      sp <= rb_sp_snap;
      stack[rb_sp_snap - ONE] <= rb_ras_snap[XLEN-1:0];
      stack[rb_sp_snap - TWO] <= rb_ras_snap[2*XLEN-1:XLEN];
    end else if (update_ras && !ex_is_ret) begin
      stack[sp] <= actual_return_address;
      sp <= sp + ONE;
    end else if (update_ras) begin
      sp <= sp - ONE;
    end
  end

endmodule

// File: tb/tb_pd_stage.sv
// Directed bench for pd_stage: stimulus queues expected outputs and a
// monitor compares them against the DUT on the falling clock edge.
module tb_pd_stage;

  logic        CLK = 1'b0;
  logic        reset;
  logic        actual_taken, mispredict, restore_ghr, restore_ras;
  logic        update_pht, update_btb, update_ras, ex_is_ret, ex_is_branch;
  logic [31:0] actual_target_address, actual_return_address, ex_pc;
  logic [8:0]  ghr_snap, rb_pht_index;
  logic [2:0]  rb_sp_snap;
  logic [63:0] rb_ras_snap;
  logic [31:0] pd_pc, pd_pred_target1, pd_pred_target2;
  logic        pd_pred_taken1, pd_pred_taken2, pd_btb_hit1, pd_btb_hit2;
  logic [8:0]  pd_pht_index1, pd_pht_index2, pd_prev_ghr;
  logic [2:0]  pd_sp_snap;
  logic [63:0] pd_ras_snap;

  pd_stage dut (
    .CLK(CLK), .reset(reset),
    .actual_taken(actual_taken), .mispredict(mispredict),
    .restore_ghr(restore_ghr), .restore_ras(restore_ras),
    .update_pht(update_pht), .update_btb(update_btb),
    .update_ras(update_ras), .ex_is_ret(ex_is_ret),
    .ex_is_branch(ex_is_branch),
    .actual_target_address(actual_target_address),
    .actual_return_address(actual_return_address),
    .ex_pc(ex_pc), .ghr_snap(ghr_snap), .rb_pht_index(rb_pht_index),
    .rb_sp_snap(rb_sp_snap), .rb_ras_snap(rb_ras_snap),
    .pd_pc(pd_pc), .pd_pred_taken1(pd_pred_taken1),
    .pd_pred_taken2(pd_pred_taken2), .pd_btb_hit1(pd_btb_hit1),
    .pd_btb_hit2(pd_btb_hit2), .pd_pred_target1(pd_pred_target1),
    .pd_pred_target2(pd_pred_target2), .pd_pht_index1(pd_pht_index1),
    .pd_pht_index2(pd_pht_index2), .pd_sp_snap(pd_sp_snap),
    .pd_ras_snap(pd_ras_snap), .pd_prev_ghr(pd_prev_ghr)
  );

  always #5 CLK = ~CLK;

  typedef enum int {
    S_PC, S_T1, S_T2, S_H1, S_H2, S_TG1, S_TG2,
    S_I1, S_I2, S_SP, S_RAS, S_GHR
  } sel_t;

  typedef struct {
    sel_t        sel;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [63:0] act(input sel_t s);
    case (s)
      S_PC:  return {32'h0, pd_pc};
      S_T1:  return {63'h0, pd_pred_taken1};
      S_T2:  return {63'h0, pd_pred_taken2};
      S_H1:  return {63'h0, pd_btb_hit1};
      S_H2:  return {63'h0, pd_btb_hit2};
      S_TG1: return {32'h0, pd_pred_target1};
      S_TG2: return {32'h0, pd_pred_target2};
      S_I1:  return {55'h0, pd_pht_index1};
      S_I2:  return {55'h0, pd_pht_index2};
      S_SP:  return {61'h0, pd_sp_snap};
      S_RAS: return pd_ras_snap;
      default: return {55'h0, pd_prev_ghr};
    endcase
  endfunction

  always @(negedge CLK) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [63:0] a;
      e = exp_q.pop_front();
      a = act(e.sel);
      checks++;
      if (a !== e.val) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", e.name, a, e.val);
      end
    end
  end

  task automatic expect_v(input sel_t s, input logic [63:0] v,
                          input string n);
    exp_q.push_back('{sel: s, val: v, name: n});
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_in();
    actual_taken = 0; mispredict = 0; restore_ghr = 0; restore_ras = 0;
    update_pht = 0; update_btb = 0; update_ras = 0; ex_is_ret = 0;
    ex_is_branch = 0; actual_target_address = 0;
    actual_return_address = 0; ex_pc = 0; ghr_snap = 0;
    rb_pht_index = 0; rb_sp_snap = 0; rb_ras_snap = 0;
  endtask

  initial begin
    clear_in();
    reset = 1;
    tick();
    tick();
    expect_v(S_PC, 0, "rst_pc");
    expect_v(S_H1, 0, "rst_hit1");
    expect_v(S_H2, 0, "rst_hit2");
    expect_v(S_T1, 0, "rst_taken1");
    expect_v(S_TG1, 8, "rst_target1");
    expect_v(S_GHR, 0, "rst_ghr");
    expect_v(S_SP, 0, "rst_sp");
    reset = 0;

    // idle sequential fetch
    tick();
    expect_v(S_PC, 8, "idle_pc8");
    tick();
    expect_v(S_PC, 16, "idle_pc16");
    expect_v(S_H1, 0, "idle_hit1");
    expect_v(S_H2, 0, "idle_hit2");
    expect_v(S_GHR, 0, "idle_ghr");

    // JAL at 0x10 -> 0x8, redirect to 0x8
    update_btb = 1; mispredict = 1; actual_taken = 1;
    ex_pc = 32'h10; actual_target_address = 32'h8;
    tick();
    clear_in();
    expect_v(S_PC, 32'h8, "jal_redirect");
    tick();
    expect_v(S_PC, 32'h10, "jal_pc");
    expect_v(S_H1, 1, "jal_hit1");
    expect_v(S_T1, 1, "jal_taken1");
    expect_v(S_TG1, 32'h8, "jal_target1");
    expect_v(S_I1, 4, "jal_idx1");

    // branch at 0x0 -> 0x40, train PHT[0] to 11
    update_btb = 1; ex_is_branch = 1; ex_pc = 0;
    actual_target_address = 32'h40;
    update_pht = 1; rb_pht_index = 0; actual_taken = 1;
    tick();
    clear_in();
    update_pht = 1; rb_pht_index = 0; actual_taken = 1;
    mispredict = 1; actual_target_address = 0;
    tick();
    clear_in();
    expect_v(S_PC, 0, "br_pc0");
    expect_v(S_H1, 1, "br_hit1");
    expect_v(S_T1, 1, "br_taken1");
    expect_v(S_TG1, 32'h40, "br_target1");
    expect_v(S_T2, 0, "br_taken2_forced");
    expect_v(S_I1, 0, "br_idx1");
    expect_v(S_I2, 1, "br_idx2");
    tick();
    expect_v(S_PC, 32'h40, "br_pc40");
    expect_v(S_GHR, 1, "br_ghr");

    // call pushes return address
    update_ras = 1; actual_return_address = 32'h44444444;
    tick();
    clear_in();
    expect_v(S_SP, 1, "call_sp");
    // return at 0x104 (slot2 of 0x100)
    update_btb = 1; ex_is_ret = 1; ex_pc = 32'h104;
    mispredict = 1; actual_taken = 1; actual_target_address = 32'h100;
    tick();
    clear_in();
    expect_v(S_PC, 32'h100, "ret_pc");
    expect_v(S_H1, 0, "ret_hit1");
    expect_v(S_H2, 1, "ret_hit2");
    expect_v(S_T1, 0, "ret_taken1");
    expect_v(S_T2, 1, "ret_taken2");
    expect_v(S_TG2, 32'h44444444, "ret_target2");
    expect_v(S_RAS, 64'h0000_0000_4444_4444, "ret_ras_snap");
    tick();
    expect_v(S_PC, 32'h44444444, "ret_follow");
    expect_v(S_GHR, 1, "ret_ghr_hold");

    // repair RAS and GHR together
    restore_ras = 1; rb_sp_snap = 4;
    rb_ras_snap = 64'hAAAAAAAA_88888888;
    restore_ghr = 1; ghr_snap = 9'h155; ex_is_branch = 1; actual_taken = 1;
    tick();
    clear_in();
    expect_v(S_SP, 4, "rep_sp");
    expect_v(S_RAS, 64'hAAAAAAAA_88888888, "rep_ras");
    expect_v(S_GHR, 9'h0AB, "rep_ghr");
    update_ras = 1; ex_is_ret = 1;
    tick();
    clear_in();
    expect_v(S_SP, 3, "pop_sp");

    // reset mid-run clears state without waiting for a clock
    mispredict = 1; ex_pc = 32'hFFC;
    tick();
    clear_in();
    expect_v(S_PC, 32'h1000, "pre_rst_pc");
    tick();
    reset = 1;
    #1;
    expect_v(S_PC, 0, "mid_rst_pc");
    expect_v(S_GHR, 0, "mid_rst_ghr");
    expect_v(S_SP, 0, "mid_rst_sp");
    expect_v(S_H1, 0, "mid_rst_hit1");
    expect_v(S_T1, 0, "mid_rst_taken1");
    tick();
    reset = 0;

    repeat (3) @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
